// File: rtl/sdiv_param_ctrl.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor.
// Signed or unsigned operands, divide-by-zero and overflow flags, a
// Start/Ready/Done handshake and an operand latch. Controller, iteration
// counter and datapath live together in this one module.
module sdiv_param_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             SignedMode,
   input  logic [2*N-1:0]   word1,
   input  logic [N-1:0]     word2,
   output logic [N-1:0]     quotient,
   output logic [N-1:0]     remainder,
   output logic             Ready,
   output logic             Done,
   output logic             DivZero,
   output logic             Overflow,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ITER  = 3'd2,
      S_FIX   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Largest representable positive and negative quotient magnitudes in signed mode
   localparam logic [N-1:0] Q_POS_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] Q_NEG_MAX = {1'b1, {(N-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

   // Magnitude of the dividend; raw value in unsigned mode
   function automatic logic [2*N-1:0] mag_dvd(input logic [2*N-1:0] v, input logic sm);
      return (sm && v[2*N-1]) ? -v : v;
   endfunction

   // Magnitude of the divisor; raw value in unsigned mode
   function automatic logic [N-1:0] mag_dvs(input logic [N-1:0] v, input logic sm);
      return (sm && v[N-1]) ? -v : v;
   endfunction

   // Conditional two's-complement negation of an N-bit result
   function automatic logic [N-1:0] apply_sign(input logic [N-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_t             state_q, state_d;
   logic [2*N-1:0]     dvd_q, dvd_d;
   logic [N-1:0]       dvs_q, dvs_d;
   logic               smode_q, smode_d;
   logic [2*N-1:0]     rq_q, rq_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N-1:0]       quo_q, quo_d;
   logic [N-1:0]       rem_q, rem_d;
   logic               dz_q, dz_d;
   logic               ov_q, ov_d;

   logic [2*N-1:0]     dvd_mag;
   logic [N-1:0]       dvs_mag;
   logic [N:0]         trial_hi;
   logic [N-1:0]       trial_diff;
   logic [N-1:0]       q_mag;
   logic [N-1:0]       r_mag;
   logic               neg_q;
   logic               neg_r;
   logic               sgn_ovf;

   // Next-state, datapath and result computation for every FSM state
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      smode_d = smode_q;
      rq_d    = rq_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ov_d    = ov_q;

      dvd_mag    = mag_dvd(dvd_q, smode_q);
      dvs_mag    = mag_dvs(dvs_q, smode_q);
      // Shifted partial remainder is N+1 bits wide; the difference fits N bits when it is kept
      trial_hi   = rq_q[2*N-1:N-1];
      trial_diff = trial_hi[N-1:0] - dvs_mag;
      q_mag      = rq_q[N-1:0];
      r_mag      = rq_q[2*N-1:N];
      neg_q      = smode_q & (dvd_q[2*N-1] ^ dvs_q[N-1]);
      neg_r      = smode_q & dvd_q[2*N-1];
      sgn_ovf    = neg_q ? (q_mag > Q_NEG_MAX) : (q_mag > Q_POS_MAX);

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               dvd_d   = word1;
               dvs_d   = word2;
               smode_d = SignedMode;
               dz_d    = 1'b0;
               ov_d    = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (dvs_q == '0) begin
               dz_d    = 1'b1;
               quo_d   = '1;
               rem_d   = dvd_q[N-1:0];
               state_d = S_DONE;
            end else if (dvd_mag[2*N-1:N] >= dvs_mag) begin
               ov_d    = 1'b1;
               quo_d   = '0;
               rem_d   = '0;
               state_d = S_DONE;
            end else begin
               rq_d    = dvd_mag;
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (trial_hi >= {1'b0, dvs_mag}) begin
               rq_d = {trial_diff, rq_q[N-2:0], 1'b1};
            end else begin
               rq_d = {rq_q[2*N-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (smode_q && sgn_ovf) begin
               ov_d  = 1'b1;
               quo_d = '0;
               rem_d = '0;
            end else begin
               quo_d = apply_sign(q_mag, neg_q);
               rem_d = apply_sign(r_mag, neg_r);
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and returns to IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         smode_q <= 1'b0;
         rq_q    <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         smode_q <= smode_d;
         rq_q    <= rq_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign DivZero   = dz_q;
   assign Overflow  = ov_q;
   assign Ready     = (state_q == S_IDLE);
   assign Done      = (state_q == S_DONE);
   assign state     = state_q;

endmodule

// File: tb/tb_sdiv_param_ctrl.sv
// Self-checking bench for sdiv_param_ctrl (N=4): directed cases plus a
// randomized sweep compared against an arithmetic reference model.
module tb_sdiv_param_ctrl;

   localparam int N     = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             Start;
   logic             SignedMode;
   logic [2*N-1:0]   word1;
   logic [N-1:0]     word2;
   logic [N-1:0]     quotient;
   logic [N-1:0]     remainder;
   logic             Ready;
   logic             Done;
   logic             DivZero;
   logic             Overflow;
   logic [2:0]       state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sdiv_param_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .Start      (Start),
      .SignedMode (SignedMode),
      .word1      (word1),
      .word2      (word2),
      .quotient   (quotient),
      .remainder  (remainder),
      .Ready      (Ready),
      .Done       (Done),
      .DivZero    (DivZero),
      .Overflow   (Overflow),
      .state      (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero, with range checks
   function automatic void model(input logic [2*N-1:0] w1, input logic [N-1:0] w2,
                                 input logic sm,
                                 output logic [N-1:0] q, output logic [N-1:0] r,
                                 output logic dz, output logic ov, output int lat);
      int a, b, qi, ri, ma, mb;
      dz = 1'b0; ov = 1'b0; q = '0; r = '0; lat = N + 3;
      if (w2 == '0) begin
         dz  = 1'b1;
         q   = '1;
         r   = w1[N-1:0];
         lat = 2;
         return;
      end
      if (sm) begin
         a  = $signed(w1);
         b  = $signed(w2);
         ma = (a < 0) ? -a : a;
         mb = (b < 0) ? -b : b;
         if (ma / mb >= (1 << N)) lat = 2;
         qi = a / b;
         ri = a % b;
         if (qi > (1 << (N-1)) - 1 || qi < -(1 << (N-1))) ov = 1'b1;
      end else begin
         a  = int'(w1);
         b  = int'(w2);
         qi = a / b;
         ri = a % b;
         if (qi >= (1 << N)) begin
            ov  = 1'b1;
            lat = 2;
         end
      end
      if (!ov) begin
         q = qi[N-1:0];
         r = ri[N-1:0];
      end
   endfunction

   task automatic issue(input logic [2*N-1:0] w1, input logic [N-1:0] w2, input logic sm);
      int n = 0;
      @(negedge clk);
      while (!Ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(Ready), 32'd1);
      word1 = w1; word2 = w2; SignedMode = sm; Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      check("busy_after_start", 32'(Ready), 32'd0);
   endtask

   task automatic wait_done(output int lat);
      int cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!Done && cyc < 50);
      if (!Done) check("done_timeout", 32'd0, 32'd1);
      lat = cyc + 1;
   endtask

   task automatic run_and_check(input logic [2*N-1:0] w1, input logic [N-1:0] w2,
                                input logic sm, input string tag);
      logic [N-1:0] eq, er;
      logic edz, eov;
      int elat, lat;
      model(w1, w2, sm, eq, er, edz, eov, elat);
      issue(w1, w2, sm);
      wait_done(lat);
      check({tag, "_lat"}, 32'(lat), 32'(elat));
      check({tag, "_q"},   32'(quotient), 32'(eq));
      check({tag, "_r"},   32'(remainder), 32'(er));
      check({tag, "_dz"},  32'(DivZero), 32'(edz));
      check({tag, "_ov"},  32'(Overflow), 32'(eov));
      if (!sm && !DivZero && !Overflow) begin
         check({tag, "_inv"}, 32'(quotient) * 32'(word2) + 32'(remainder), 32'(word1));
         check({tag, "_rlt"}, 32'(remainder < word2), 32'd1);
      end
      @(posedge clk);
      #1 check({tag, "_pulse"}, 32'(Done), 32'd0);
   endtask

   initial begin
      int lat, n, idle, seen;
      logic [2*N-1:0] rw1;
      logic [N-1:0]   rw2;
      reset = 1'b1; Start = 1'b0; SignedMode = 1'b0; word1 = '0; word2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ready", 32'(Ready), 32'd1);
      check("rst_done",  32'(Done), 32'd0);
      check("rst_q",     32'(quotient), 32'd0);
      check("rst_r",     32'(remainder), 32'd0);
      check("rst_dz",    32'(DivZero), 32'd0);
      check("rst_ov",    32'(Overflow), 32'd0);
      reset = 1'b0;

      // Directed cases
      run_and_check(8'h64, 4'h7, 1'b0, "u100_7");
      check("u100_7_q14", 32'(quotient), 32'd14);
      check("u100_7_r2",  32'(remainder), 32'd2);
      run_and_check(8'hCE, 4'h7, 1'b1, "s_m50_7");
      check("s_m50_7_q9", 32'(quotient), 32'h9);
      check("s_m50_7_rF", 32'(remainder), 32'hF);
      run_and_check(8'hC8, 4'h7, 1'b1, "s_m56_7");
      check("s_m56_7_q8", 32'(quotient), 32'h8);
      run_and_check(8'h35, 4'h0, 1'b0, "divzero");
      check("divzero_qF", 32'(quotient), 32'hF);
      run_and_check(8'h70, 4'h7, 1'b0, "u_ovf");
      run_and_check(8'h40, 4'h7, 1'b1, "s_ovf_fix");
      run_and_check(8'h80, 4'h8, 1'b1, "s_m128_m8");
      run_and_check(8'hFF, 4'hF, 1'b0, "u_255_15");

      // Start pulsed during ITER must be ignored
      issue(8'h64, 4'h7, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      word1 = 8'h33; word2 = 4'h3; Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      wait_done(lat);
      check("ign_q", 32'(quotient), 32'd14);
      check("ign_r", 32'(remainder), 32'd2);
      @(posedge clk);
      #1;
      check("ign_idle", 32'(state), 32'd0);
      @(posedge clk);
      #1 check("ign_still_idle", 32'(state), 32'd0);

      // Start held high: one IDLE cycle between consecutive Done pulses
      @(negedge clk);
      word1 = 8'h64; word2 = 4'h7; SignedMode = 1'b0; Start = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!Done && n < 50);
      check("b2b_first_done", 32'(Done), 32'd1);
      idle = 0; n = 0;
      do begin
         @(posedge clk);
         #1;
         if (Ready) idle++;
         n++;
      end while (!Done && n < 50);
      Start = 1'b0;
      check("b2b_second_done", 32'(Done), 32'd1);
      check("b2b_idle_cycles", 32'(idle), 32'd1);
      check("b2b_q", 32'(quotient), 32'd14);

      // Reset in the middle of ITER aborts without a Done pulse
      issue(8'h64, 4'h7, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_ready", 32'(Ready), 32'd1);
      check("mid_rst_done",  32'(Done), 32'd0);
      check("mid_rst_q",     32'(quotient), 32'd0);
      check("mid_rst_r",     32'(remainder), 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (N + 5) begin
         @(posedge clk);
         #1;
         if (Done) seen = 1;
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);

      // Randomized sweep: unsigned then signed
      for (int i = 0; i < 150; i++) begin
         rw1 = (2*N)'($urandom_range(0, (1 << (2*N)) - 1));
         rw2 = N'($urandom_range(0, (1 << N) - 1));
         run_and_check(rw1, rw2, 1'b0, "rnd_u");
      end
      for (int i = 0; i < 100; i++) begin
         rw1 = (2*N)'($urandom_range(0, (1 << (2*N)) - 1));
         rw2 = N'($urandom_range(0, (1 << N) - 1));
         run_and_check(rw1, rw2, 1'b1, "rnd_s");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
